// File: rtl/ctoc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctoc_pkg
// Shared constants and types for the control-to-core link framer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ctoc_pkg;

   // TX word bit positions
   localparam int CTOC_VALID = 69;
   localparam int CTOC_AW    = 68;
   localparam int CTOC_WLAST = 67;
   localparam int CTOC_W     = 66;
   localparam int CTOC_AR    = 65;

   // RX response word bit positions
   localparam int CTOC_B     = 68;
   localparam int CTOC_RLAST = 67;
   localparam int CTOC_R     = 66;

   // Training pattern: one 5'h01 symbol on each of the 14 lanes
   localparam logic [69:0] CTOC_TRAIN_PAT = {14{5'h01}};

   // Address-channel command as packed into AW/AR link words
   typedef struct packed {
      logic [5:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ctoc_cmd_t;

   typedef enum logic [1:0] {
      ST_DOWN  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_IDLE  = 2'd2,
      ST_WDATA = 2'd3
   } ctoc_state_e;

endpackage
`default_nettype wire

// File: rtl/ctoc_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctoc_id_fifo
// Small synchronous FIFO holding outstanding read IDs in issue order.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ctoc_id_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Storage write; a flush discards the same-cycle push
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

   // Pointer update; extra MSB distinguishes full from empty
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ctoc_master_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctoc_master_framer
// Control-side link framer: packs AXI AW/W/AR into 70-bit TX words, decodes
// 69-bit RX words into B/R pulses, runs link training and credit tracking.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ctoc_master_framer
   import ctoc_pkg::*;
#(
   parameter int TRAIN_CYCLES = 65535,
   parameter int MAX_OUTST    = 8
) (
   input  logic        s_aclk,
   input  logic        s_aresetn,
   input  logic        link_up,
   input  logic [5:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [63:0] wdata,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   input  logic [5:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [5:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   output logic [5:0]  rid,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   output logic [69:0] tx_word,
   input  logic [68:0] rx_word,
   input  logic        rx_valid,
   output logic        training,
   output logic        proto_err
);

   localparam int CNT_W = $clog2(TRAIN_CYCLES + 1);
   localparam int CRD_W = $clog2(MAX_OUTST) + 1;
   localparam int SUM_W = CRD_W + 1;
   localparam logic [CRD_W-1:0] MAX_CRD = CRD_W'(MAX_OUTST);

   ctoc_state_e      state_q, state_d;
   logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
   logic [CRD_W-1:0] credits_q, credits_d;
   logic             rr_aw_q, rr_aw_d;   // AW holds priority on the next tie
   logic [69:0]      tx_word_q, tx_word_d;
   logic             proto_err_q, proto_err_d;
   logic             bvalid_q, rvalid_q, rlast_q;
   logic [5:0]       bid_q, rid_q;
   logic [1:0]       bresp_q;
   logic [63:0]      rdata_q;

   ctoc_cmd_t        aw_cmd, ar_cmd;
   logic             can_issue, ar_grant, aw_grant, w_beat;
   logic             rx_ok, b_evt, r_evt, r_last;
   logic             fifo_empty;
   logic [5:0]       fifo_head;
   logic [SUM_W-1:0] crd_sum, crd_dec;
   logic             crd_under;
   logic             unused_rx;

   assign aw_cmd = {awid, awaddr, awlen, awsize, awburst};
   assign ar_cmd = {arid, araddr, arlen, arsize, arburst};

   // Requests are only accepted while the link is up and credits remain
   assign can_issue = link_up && (state_q == ST_IDLE) && (credits_q < MAX_CRD);
   assign w_beat    = link_up && (state_q == ST_WDATA) && wvalid;

   // Single address grant per cycle, round-robin on AR/AW ties
   always_comb begin
      ar_grant = 1'b0;
      aw_grant = 1'b0;
      rr_aw_d  = rr_aw_q;
      if (can_issue) begin
         if (arvalid && awvalid) begin
            ar_grant = !rr_aw_q;
            aw_grant = rr_aw_q;
            rr_aw_d  = !rr_aw_q;
         end else begin
            ar_grant = arvalid;
            aw_grant = awvalid;
         end
      end
   end

   assign arready = ar_grant;
   assign awready = aw_grant;
   assign wready  = link_up && (state_q == ST_WDATA);

   // Link state machine; losing the link always forces DOWN
   always_comb begin
      state_d     = state_q;
      train_cnt_d = train_cnt_q;
      if (!link_up) begin
         state_d = ST_DOWN;
      end else begin
         case (state_q)
            ST_DOWN: begin
               state_d     = ST_TRAIN;
               train_cnt_d = '0;
            end
            ST_TRAIN: begin
               if (train_cnt_q == CNT_W'(TRAIN_CYCLES - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  train_cnt_d = train_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (aw_grant) begin
                  state_d = ST_WDATA;
               end
            end
            ST_WDATA: begin
               if (wvalid && wlast) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_DOWN;
         endcase
      end
   end

   // Next TX word, keyed on next state so it lines up with the training flag
   always_comb begin
      tx_word_d = '0;
      if (state_d == ST_TRAIN) begin
         tx_word_d = CTOC_TRAIN_PAT;
      end else if (ar_grant) begin
         tx_word_d[CTOC_VALID] = 1'b1;
         tx_word_d[CTOC_AR]    = 1'b1;
         tx_word_d[50:0]       = ar_cmd;
      end else if (aw_grant) begin
         tx_word_d[CTOC_VALID] = 1'b1;
         tx_word_d[CTOC_AW]    = 1'b1;
         tx_word_d[50:0]       = aw_cmd;
      end else if (w_beat) begin
         tx_word_d[CTOC_VALID] = 1'b1;
         tx_word_d[CTOC_W]     = 1'b1;
         tx_word_d[CTOC_WLAST] = wlast;
         tx_word_d[63:0]       = wdata;
      end
   end

   // Response decode is only meaningful once the link is trained
   assign rx_ok  = rx_valid && (rx_word != '0) &&
                   ((state_q == ST_IDLE) || (state_q == ST_WDATA));
   assign b_evt  = rx_ok && rx_word[CTOC_B];
   assign r_evt  = rx_ok && rx_word[CTOC_R];
   assign r_last = r_evt && rx_word[CTOC_RLAST];
   assign unused_rx = ^rx_word[65:64];

   // Credit arithmetic; B and R-last in one word return two credits
   always_comb begin
      crd_sum     = {1'b0, credits_q} + SUM_W'(ar_grant | aw_grant);
      crd_dec     = SUM_W'(b_evt) + SUM_W'(r_last);
      crd_under   = (crd_sum < crd_dec);
      credits_d   = crd_under ? '0 : CRD_W'(crd_sum - crd_dec);
      if (!link_up) begin
         credits_d = '0;
      end
      proto_err_d = proto_err_q | crd_under | (r_evt && fifo_empty) | (b_evt && r_evt);
   end

   ctoc_id_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (6)
   ) u_id_fifo (
      .clk_i   (s_aclk),
      .rst_ni  (s_aresetn),
      .push_i  (ar_grant),
      .din_i   (arid),
      .pop_i   (r_last),
      .flush_i (!link_up),
      .dout_o  (fifo_head),
      .empty_o (fifo_empty)
   );

   // State, counters and registered outputs
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state_q     <= ST_DOWN;
         train_cnt_q <= '0;
         credits_q   <= '0;
         rr_aw_q     <= 1'b0;
         tx_word_q   <= '0;
         proto_err_q <= 1'b0;
         bvalid_q    <= 1'b0;
         bid_q       <= '0;
         bresp_q     <= '0;
         rvalid_q    <= 1'b0;
         rid_q       <= '0;
         rdata_q     <= '0;
         rlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         train_cnt_q <= train_cnt_d;
         credits_q   <= credits_d;
         rr_aw_q     <= rr_aw_d;
         tx_word_q   <= tx_word_d;
         proto_err_q <= proto_err_d;
         bvalid_q    <= b_evt;
         rvalid_q    <= r_evt;
         if (b_evt) begin
            {bid_q, bresp_q} <= rx_word[7:0];
         end
         if (r_evt) begin
            rdata_q <= rx_word[63:0];
            rlast_q <= rx_word[CTOC_RLAST];
            rid_q   <= fifo_empty ? 6'd0 : fifo_head;
         end
      end
   end

   assign tx_word   = tx_word_q;
   assign training  = (state_q == ST_TRAIN);
   assign proto_err = proto_err_q;
   assign bvalid    = bvalid_q;
   assign bid       = bid_q;
   assign bresp     = bresp_q;
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign rdata     = rdata_q;
   assign rlast     = rlast_q;
   assign rresp     = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_ctoc_master_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ctoc_master_framer
// Directed self-checking bench for the link framer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ctoc_master_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        link_up = 1'b0;
   logic [5:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [63:0] wdata = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [5:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [5:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic [5:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic [69:0] tx_word;
   logic [68:0] rx_word = '0;
   logic        rx_valid = 1'b0;
   logic        training;
   logic        proto_err;

   int total = 0;
   int bad   = 0;
   logic [69:0] pat;
   logic [69:0] exp;

   always #5 clk = ~clk;

   ctoc_master_framer #(
      .TRAIN_CYCLES (16),
      .MAX_OUTST    (8)
   ) dut (
      .s_aclk    (clk),
      .s_aresetn (rst_n),
      .link_up   (link_up),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .rid       (rid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .tx_word   (tx_word),
      .rx_word   (rx_word),
      .rx_valid  (rx_valid),
      .training  (training),
      .proto_err (proto_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({tx_word, training, proto_err, bvalid, rvalid, awready, arready, wready} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: tx=%h trn=%b err=%b bv=%b rv=%b", tx_word, training, proto_err, bvalid, rvalid);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_training();
      int errs;
      errs = 0;
      for (int i = 0; i < 14; i++) pat[i*5 +: 5] = 5'h01;
      link_up = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         total++;
         if (tx_word !== pat || training !== 1'b1 || {awready, arready, wready} !== 3'b000) begin
            bad++;
            $display("FAIL train_cycle%0d: tx=%h trn=%b want tx=%h trn=1", i, tx_word, training, pat);
         end
      end
      tick();
      total++;
      if (tx_word !== 70'h0 || training !== 1'b0) begin
         bad++;
         $display("FAIL train_end: tx=%h trn=%b want 0 0", tx_word, training);
      end
   endtask

   task automatic test_write();
      awid = 6'd5; awaddr = 32'h1000; awlen = 8'd1; awsize = 3'd3; awburst = 2'd1;
      awvalid = 1'b1;
      #1;
      total++;
      if (awready !== 1'b1) begin bad++; $display("FAIL aw_ready: got %b want 1", awready); end
      tick();
      awvalid = 1'b0;
      exp = '0; exp[69] = 1'b1; exp[68] = 1'b1;
      exp[50:0] = {6'd5, 32'h0000_1000, 8'd1, 3'd3, 2'd1};
      total++;
      if (tx_word !== exp) begin bad++; $display("FAIL aw_word: got %h want %h", tx_word, exp); end
      wvalid = 1'b1; wdata = 64'hA5A5_A5A5_A5A5_A5A5; wlast = 1'b0;
      #1;
      total++;
      if (wready !== 1'b1 || awready !== 1'b0) begin bad++; $display("FAIL w_ready: got w=%b aw=%b want 1 0", wready, awready); end
      tick();
      exp = '0; exp[69] = 1'b1; exp[66] = 1'b1; exp[63:0] = 64'hA5A5_A5A5_A5A5_A5A5;
      total++;
      if (tx_word !== exp) begin bad++; $display("FAIL w_beat0: got %h want %h", tx_word, exp); end
      wdata = 64'hA5A5_A5A5_A5A5_A5A6; wlast = 1'b1;
      tick();
      wvalid = 1'b0; wlast = 1'b0;
      exp = '0; exp[69] = 1'b1; exp[67] = 1'b1; exp[66] = 1'b1; exp[63:0] = 64'hA5A5_A5A5_A5A5_A5A6;
      total++;
      if (tx_word !== exp) begin bad++; $display("FAIL w_beat1: got %h want %h", tx_word, exp); end
      total++;
      if (dut.credits_q !== 4'd1) begin bad++; $display("FAIL credits_after_aw: got %0d want 1", dut.credits_q); end
   endtask

   task automatic test_bresp();
      rx_word = '0; rx_word[68] = 1'b1; rx_word[7:0] = {6'd5, 2'b00};
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      total++;
      if (bvalid !== 1'b1 || bid !== 6'd5 || bresp !== 2'd0 || rvalid !== 1'b0) begin
         bad++;
         $display("FAIL b_resp: got bv=%b bid=%0d br=%0d rv=%b want 1 5 0 0", bvalid, bid, bresp, rvalid);
      end
      tick();
      total++;
      if (bvalid !== 1'b0 || dut.credits_q !== 4'd0) begin
         bad++;
         $display("FAIL b_done: got bv=%b credits=%0d want 0 0", bvalid, dut.credits_q);
      end
   endtask

   task automatic test_credit_limit();
      for (int i = 0; i < 8; i++) begin
         arid = 6'(i); araddr = 32'h2000 + 32'(i * 16); arlen = 8'd0; arsize = 3'd3; arburst = 2'd1;
         arvalid = 1'b1;
         #1;
         total++;
         if (arready !== 1'b1) begin bad++; $display("FAIL ar_ready%0d: got %b want 1", i, arready); end
         tick();
         exp = '0; exp[69] = 1'b1; exp[65] = 1'b1;
         exp[50:0] = {6'(i), 32'h2000 + 32'(i * 16), 8'd0, 3'd3, 2'd1};
         total++;
         if (tx_word !== exp) begin bad++; $display("FAIL ar_word%0d: got %h want %h", i, tx_word, exp); end
      end
      arid = 6'd8; araddr = 32'h2080;
      #1;
      total++;
      if (arready !== 1'b0) begin bad++; $display("FAIL ar_full: got %b want 0", arready); end
      tick();
      total++;
      if (tx_word !== 70'h0 || arready !== 1'b0) begin bad++; $display("FAIL ar_blocked: tx=%h ardy=%b want 0 0", tx_word, arready); end
      rx_word = '0; rx_word[66] = 1'b1; rx_word[67] = 1'b1; rx_word[63:0] = 64'hDEAD_BEEF_0000_0001;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      total++;
      if (rvalid !== 1'b1 || rid !== 6'd0 || rlast !== 1'b1 || rresp !== 2'd0 || rdata !== 64'hDEAD_BEEF_0000_0001) begin
         bad++;
         $display("FAIL r_first: rv=%b rid=%0d rl=%b rr=%0d rd=%h want 1 0 1 0 deadbeef00000001", rvalid, rid, rlast, rresp, rdata);
      end
      total++;
      if (arready !== 1'b1) begin bad++; $display("FAIL ar_after_free: got %b want 1", arready); end
      tick();
      arvalid = 1'b0;
      exp = '0; exp[69] = 1'b1; exp[65] = 1'b1; exp[50:0] = {6'd8, 32'h2080, 8'd0, 3'd3, 2'd1};
      total++;
      if (tx_word !== exp) begin bad++; $display("FAIL ar_ninth: got %h want %h", tx_word, exp); end
      // Non-last beat must not pop the ID FIFO
      rx_word = '0; rx_word[66] = 1'b1; rx_word[63:0] = 64'h11;
      rx_valid = 1'b1;
      tick();
      total++;
      if (rvalid !== 1'b1 || rid !== 6'd1 || rlast !== 1'b0) begin
         bad++;
         $display("FAIL r_nonlast: rv=%b rid=%0d rl=%b want 1 1 0", rvalid, rid, rlast);
      end
      for (int k = 1; k <= 8; k++) begin
         rx_word = '0; rx_word[66] = 1'b1; rx_word[67] = 1'b1; rx_word[63:0] = 64'(k);
         tick();
         total++;
         if (rvalid !== 1'b1 || rid !== 6'(k) || rdata !== 64'(k)) begin
            bad++;
            $display("FAIL r_drain%0d: rv=%b rid=%0d rd=%h want 1 %0d %0d", k, rvalid, rid, rdata, k, k);
         end
      end
      rx_valid = 1'b0;
      tick();
      total++;
      if (rvalid !== 1'b0 || dut.credits_q !== 4'd0 || proto_err !== 1'b0) begin
         bad++;
         $display("FAIL r_drained: rv=%b credits=%0d err=%b want 0 0 0", rvalid, dut.credits_q, proto_err);
      end
   endtask

   task automatic test_back_to_back();
      arid = 6'd10; araddr = 32'h3000; arvalid = 1'b1;
      awid = 6'd20; awaddr = 32'h4000; awlen = 8'd0; awvalid = 1'b1;
      #1;
      total++;
      if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL tie0: got ar=%b aw=%b want 1 0", arready, awready); end
      tick();
      total++;
      if ({arready, awready} !== 2'b01) begin bad++; $display("FAIL tie1: got ar=%b aw=%b want 0 1", arready, awready); end
      tick();
      total++;
      if ({arready, awready} !== 2'b00) begin bad++; $display("FAIL tie_wdata: got ar=%b aw=%b want 0 0", arready, awready); end
      awvalid = 1'b0;
      wvalid = 1'b1; wlast = 1'b1; wdata = 64'h1234;
      tick();
      wvalid = 1'b0; wlast = 1'b0;
      awvalid = 1'b1;
      #1;
      total++;
      if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL tie2: got ar=%b aw=%b want 1 0", arready, awready); end
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
   endtask

   task automatic test_link_drop();
      awid = 6'd3; awaddr = 32'h5000; awlen = 8'd3; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid = 1'b1; wlast = 1'b0; wdata = 64'h5555;
      tick();
      link_up = 1'b0;
      tick();
      total++;
      if (tx_word !== 70'h0 || training !== 1'b0 || wready !== 1'b0) begin
         bad++;
         $display("FAIL link_down: tx=%h trn=%b wrdy=%b want 0 0 0", tx_word, training, wready);
      end
      total++;
      if (dut.credits_q !== 4'd0) begin bad++; $display("FAIL credits_cleared: got %0d want 0", dut.credits_q); end
      wvalid = 1'b0;
      // B word presented throughout retraining must be ignored
      rx_word = '0; rx_word[68] = 1'b1; rx_word[7:0] = 8'h14;
      rx_valid = 1'b1;
      link_up = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         total++;
         if (bvalid !== 1'b0) begin bad++; $display("FAIL rx_in_train%0d: bvalid=%b want 0", i, bvalid); end
      end
      rx_valid = 1'b0;
      tick();
      total++;
      if (training !== 1'b0 || tx_word !== 70'h0 || proto_err !== 1'b0) begin
         bad++;
         $display("FAIL retrained: trn=%b tx=%h err=%b want 0 0 0", training, tx_word, proto_err);
      end
      rx_word = '0; rx_word[66] = 1'b1; rx_word[67] = 1'b1; rx_word[63:0] = 64'h77;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      total++;
      if (rvalid !== 1'b1 || rid !== 6'd0 || proto_err !== 1'b1) begin
         bad++;
         $display("FAIL r_empty: rv=%b rid=%0d err=%b want 1 0 1", rvalid, rid, proto_err);
      end
      repeat (3) tick();
      total++;
      if (proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", proto_err); end
   endtask

   initial begin
      test_reset();
      test_training();
      test_write();
      test_bresp();
      test_credit_limit();
      test_back_to_back();
      test_link_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ctoc_master_framer.md
Name: ctoc_master_framer

Overview:
- Control-FPGA end of the control-to-core link, in the s_aclk domain.
- Accepts AXI requests (AW, W, AR) from local control logic and packs them into 70-bit link words for the TX serializer.
- Unpacks 69-bit response words from the RX clock-crossing FIFO into B and R responses.
- Owns link training, outstanding-transaction credits and read-ID tracking; the core end has no backpressure.

Parameters:
- TRAIN_CYCLES, 65535, cycles of training pattern sent after link_up rises.
- MAX_OUTST, 8, maximum outstanding AW+AR transactions (power of 2, ≥2).

Ports:
- s_aclk  in  1  clock.
- s_aresetn  in  1  asynchronous active-low reset.
- link_up  in  1  both link MMCMs locked, already synchronized to s_aclk.
- awid  in  6  write ID; awaddr  in  32; awlen  in  8; awsize  in  3; awburst  in  2.
- awvalid  in  1; awready  out  1.
- wdata  in  64; wlast  in  1; wvalid  in  1; wready  out  1.
- arid  in  6; araddr  in  32; arlen  in  8; arsize  in  3; arburst  in  2.
- arvalid  in  1; arready  out  1.
- bid  out  6; bresp  out  2; bvalid  out  1 (push-only, no bready).
- rid  out  6; rdata  out  64; rresp  out  2; rlast  out  1; rvalid  out  1 (push-only, no rready).
- tx_word  out  70  to OSERDES packing, 5 bits per lane × 14 lanes.
- rx_word  in  69  from RX FIFO dout.
- rx_valid  in  1  RX FIFO word valid.
- training  out  1  high while the pattern is sent.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0; FSM in DOWN; credits 0; ID FIFO empty.

TX word format (registered; 1-cycle latency from handshake):
- bit69 = any valid.
- bit68 = awvalid, bit67 = wlast, bit66 = wvalid, bit65 = arvalid.
- AW/AR words: [50:0] = {id, addr, len, size, burst}.
- W words: [63:0] = wdata.
- Bits 64–65 are 0 on W words.
- At most one of AW/W/AR per word.
- Idle word = 70'h0.

FSM states:
- DOWN:
  - tx_word = 0; all readys 0.
  - On link_up → TRAIN, clear training counter.
- TRAIN:
  - tx_word = {14{5'h01}}; training = 1; readys 0.
  - After TRAIN_CYCLES cycles → IDLE.
- IDLE:
  - Grant at most one of AR or AW per cycle, only if credits < MAX_OUTST.
  - Round-robin between AR and AW when both are valid; AR wins on the first tie after reset.
  - AR grant: arready = 1, emit AR word, push arid into the read-ID FIFO.
  - AW grant: awready = 1, emit AW word, → WDATA.
  - wready = 0 in IDLE.
- WDATA:
  - wready = 1; awready = arready = 0.
  - Each wvalid beat emits a W word.
  - Beat with wlast → IDLE.
  - Idle cycles are allowed (word 0).
- link_up falling in any state → DOWN next cycle; credits cleared, ID FIFO flushed, an in-flight burst is abandoned.

Credits:
- +1 on AW or AR grant.
- −1 on received bvalid, or on rvalid with rlast.
- Increment and decrement in the same cycle → unchanged.
- Decrement at 0 → counter held at 0, proto_err set.

RX decode (only when rx_valid && rx_word[68:0] nonzero && FSM is IDLE or WDATA):
- B response, when bit68:
  - bvalid = 1 next cycle.
  - {bid, bresp} = rx_word[7:0].
- R response, when bit66:
  - rvalid = 1; rdata = rx_word[63:0]; rlast = bit67; rresp = 0.
  - rid = head of the read-ID FIFO; pop on rlast.
  - R with the FIFO empty → rid = 0, proto_err set.
- Bits 68 and 66 both set → proto_err set; B and R both asserted.
- Responses are 1-cycle pulses per word, with no stalling.
- Words received in DOWN or TRAIN are ignored.

proto_err: cleared only by reset.

Decomposition:
- Package ctoc_pkg holds:
  - Bit-index constants (CTOC_VALID=69, CTOC_AW=68, CTOC_WLAST=67, CTOC_W=66, CTOC_AR=65; response CTOC_B=68, CTOC_RLAST=67, CTOC_R=66).
  - CTOC_TRAIN_PAT = {14{5'h01}}.
  - Packed struct for {id, addr, len, size, burst} (51 bits).
  - FSM enum.
- Sub-module ctoc_id_fifo: synchronous FIFO, 6-bit wide, depth MAX_OUTST, with push/pop/flush/empty.

Test Plan:
- Reset, then link_up=1 with TRAIN_CYCLES=16:
  - 16 cycles tx_word = {14{5'h01}} with training=1 and readys 0.
  - Then IDLE with tx_word 0.
- After training, AW id=5 addr=0x1000 len=1, then 2 W beats 0xA5…, wlast on the second:
  - tx_word bit68 with [50:0] matching.
  - Then 2 words with bit66, the second with bit67 set.
  - Credits = 1.
- rx_word with bit68 and [7:0] = {6'd5, 2'b00}:
  - bvalid pulse with bid=5, bresp=0.
  - Credits back to 0.
- Issue 8 ARs (ids 0–7), then a 9th:
  - arready held 0 on the 9th.
  - Return an R word with rlast → rid=0, credit freed, 9th AR granted the next cycle.
- AR and AW valid together repeatedly:
  - Grants alternate AR, AW, AR.
  - No AR is granted while in WDATA.
- link_up drops mid-burst:
  - DOWN next cycle, tx_word 0.
  - Then an R word with ID FIFO empty while back in IDLE → proto_err=1 and stays set.
